huffman_code_serializer: RTL and testbench
==========================================

Name: huffman_code_serializer

Overview:
- Parametrised streaming Huffman encoder back end: a loadable code table maps each fixed-width input symbol to a variable-length code, emitted MSB-first as a serial bitstream.
- Successor to the fixed 4-bit `main` encoder. Adds:
  - generic symbol width;
  - a runtime-loadable table;
  - valid/ready backpressure on both sides;
  - block framing (output_start/done);
  - a per-block bit count;
  - error reporting.
- Sits between the symbol source and the bit packer / output pin logic.

Parameters:
SYM_W, 4, symbol width in bits; table depth is 2**SYM_W
MAX_LEN, 15, maximum code length in bits
LEN_W, 4, width of the code-length field; must satisfy 2**LEN_W > MAX_LEN
CNT_W, 16, width of the per-block emitted-bit counter

Ports:
CLK  in  1  clock, all logic on rising edge
nRST  in  1  asynchronous active-low reset
tbl_we  in  1  table write strobe
tbl_addr  in  SYM_W  table entry (symbol) to write
tbl_code  in  MAX_LEN  code bits, right-aligned
tbl_len  in  LEN_W  code length; 0 = entry invalid
sym_in  in  SYM_W  input symbol
sym_valid  in  1  sym_in valid
sym_last  in  1  marks last symbol of a block; qualified by sym_valid
sym_ready  out  1  serializer can accept a symbol
bit_out  out  1  serial code bit
bit_valid  out  1  bit_out valid
bit_ready  in  1  downstream accepts bit
output_start  out  1  pulse with first valid bit of a block
done  out  1  pulse after last bit of a block transferred
bit_count  out  CNT_W  bits transferred in current/last block, saturating
err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, nRST=0):
  - state=IDLE; all table lengths=0 (codes may stay X);
  - sym_ready=1; bit_valid=0; bit_out=0; output_start=0; done=0; bit_count=0; err=0.
- Table:
  - Write occurs when tbl_we=1 in IDLE; registered, visible next cycle.
  - tbl_we in any other state: write ignored, err set.
  - tbl_len > MAX_LEN: write ignored, err set.
- Handshakes:
  - A symbol transfers on sym_valid & sym_ready.
  - A bit transfers on bit_valid & bit_ready.
  - bit_out is held stable while bit_valid & !bit_ready.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - sym_ready=1.
  - On symbol transfer with table len>0: load shift reg = code, remaining = len, latch last flag, go to SHIFT.
  - On symbol transfer with len=0: symbol dropped, err set, stay IDLE. If sym_last was set, go to DONE.
- SHIFT:
  - bit_valid=1; bit_out = code bit [remaining-1].
  - Each bit transfer decrements remaining and increments bit_count (saturates at all-ones).
  - sym_ready=1 only when remaining==1 & bit_ready & !last flag (zero-bubble back-to-back codes).
  - A symbol accepted on the final bit reloads directly and stays in SHIFT. A len=0 symbol accepted this way is dropped, err set, next state IDLE.
  - Final bit transferred, no new symbol: last flag set → DONE, else → IDLE.
- DONE: done=1 for exactly one cycle, sym_ready=0, then IDLE.
- Latency: symbol accepted at cycle t → first bit_valid at t+1.
- output_start:
  - One-cycle pulse coincident with the first bit_valid cycle of a block (first code after reset or after done).
  - bit_count clears to 0 in that same cycle, then counts that cycle's transfer normally.
  - Not re-pulsed while the first bit stalls.
- err: sticky; clears only on reset or at output_start of the next block.
- Reset mid-block: everything aborts immediately; partial code is lost, no done pulse.
- A block whose every symbol was dropped still produces done, but no output_start; bit_count stays at the previous value.

Decomposition:
- Package huffman_pkg: SYM_W/MAX_LEN/LEN_W defaults, the state enum, and a table-entry struct {code, len}.
- One sub-module: huffman_code_table (register array, write port with validity check, asynchronous read by symbol).
- Shift/count/FSM logic lives in the top.

Test Plan:
- Load sym9={00,len2} and sym0={10110,len5}; send 9,0(last) with bit_ready=1 → bits 0,0,1,0,1,1,0 on consecutive cycles, no bubble between codes. output_start on bit 1; done one cycle after bit 7; bit_count=7.
- Same stream with bit_ready toggling 1,0 every cycle → identical bit sequence; each bit held through its stall; sym_ready low except on the final-bit transfer cycle.
- Send symbol 3 with len=0, then symbol 9 → err=1; only bits 0,0 emitted. err clears at the output_start of the next block.
- tbl_we during SHIFT (addr 9, len 3) → entry unchanged (next 9 still emits 00), err=1.
- tbl_len=15 code 0x7FFF single-symbol block → 15 ones emitted, bit_count=15. tbl_len=15 accepted, and tbl_len=... with LEN_W=4 an overlength case needs MAX_LEN<15: for MAX_LEN=7, write len=9 → rejected, err=1.
- Drop nRST during bit 3 of a 5-bit code → bit_valid=0 and sym_ready=1 immediately, table lengths all 0. Next block starts with a fresh output_start.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman code serializer: default geometry,
// the serializer state encoding and the table-entry layout.
package huffman_pkg;

  localparam int SYM_W_DEF   = 4;
  localparam int MAX_LEN_DEF = 15;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Table entry at the default geometry; len == 0 marks the entry invalid.
  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] code;
    logic [LEN_W_DEF-1:0]   len;
  } tbl_entry_t;

endpackage

// File: rtl/huffman_code_table.sv
// Symbol -> {code, len} lookup. Registered write port that rejects
// over-long lengths, asynchronous read indexed by the incoming symbol.
module huffman_code_table #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 15,
  parameter int LEN_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [SYM_W-1:0]   waddr_i,
  input  logic [MAX_LEN-1:0] code_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [SYM_W-1:0]   raddr_i,
  output logic [MAX_LEN-1:0] rcode_o,
  output logic [LEN_W-1:0]   rlen_o,
  output logic               werr_o
);

  localparam int DEPTH = 1 << SYM_W;

  logic [MAX_LEN-1:0] code_q [DEPTH];
  logic [LEN_W-1:0]   len_q  [DEPTH];
  logic               len_ok;

  assign len_ok = (len_i <= LEN_W'(MAX_LEN));
  assign werr_o = we_i & ~len_ok;

  // Lengths reset to zero so every entry starts out invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) len_q[i] <= '0;
    end else if (we_i && len_ok) begin
      len_q[waddr_i] <= len_i;
    end
  end

  // Code bits need no reset: a zero length masks whatever they hold.
  always_ff @(posedge clk_i) begin
    if (we_i && len_ok) code_q[waddr_i] <= code_i;
  end

  assign rcode_o = code_q[raddr_i];
  assign rlen_o  = len_q[raddr_i];

endmodule

// File: rtl/huffman_code_serializer.sv
// Streaming Huffman back end: looks up each symbol's code and shifts it
// out MSB-first with valid/ready on both sides, block framing, a
// saturating per-block bit count and a sticky error flag.
module huffman_code_serializer
  import huffman_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic [SYM_W-1:0]   sym_in,
  input  logic               sym_valid,
  input  logic               sym_last,
  output logic               sym_ready,
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               output_start,
  output logic               done,
  output logic [CNT_W-1:0]   bit_count,
  output logic               err
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;     // code left-aligned, MSB is the live bit
  logic [LEN_W-1:0]   rem_q, rem_d;   // bits of the current code still to send
  logic               last_q, last_d;
  logic               open_q, open_d; // output_start already issued this block
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] ent_code;
  logic [LEN_W-1:0]   ent_len;
  logic               tbl_werr, sym_xfer, bit_xfer, final_bit;

  huffman_code_table #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_tbl (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .we_i   (tbl_we && (state_q == ST_IDLE)),
    .waddr_i(tbl_addr),
    .code_i (tbl_code),
    .len_i  (tbl_len),
    .raddr_i(sym_in),
    .rcode_o(ent_code),
    .rlen_o (ent_len),
    .werr_o (tbl_werr)
  );

  assign bit_valid    = (state_q == ST_SHIFT);
  assign bit_out      = bit_valid & sh_q[MAX_LEN-1];
  assign output_start = bit_valid & ~open_q;
  assign done         = (state_q == ST_DONE);
  assign bit_count    = cnt_q;
  assign err          = err_q;
  assign final_bit    = (rem_q == LEN_W'(1));

  // Accept a symbol in IDLE, or on the final bit of a code so codes abut.
  always_comb begin
    sym_ready = 1'b0;
    case (state_q)
      ST_IDLE:  sym_ready = 1'b1;
      ST_SHIFT: sym_ready = final_bit & bit_ready & ~last_q;
      default:  sym_ready = 1'b0;
    endcase
  end

  assign sym_xfer = sym_valid & sym_ready;
  assign bit_xfer = bit_valid & bit_ready;

  // Next-state: shift/count on each bit transfer, reload or drop on symbol transfer.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    last_d  = last_q;
    open_d  = open_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (output_start) begin
      err_d  = 1'b0;
      cnt_d  = '0;
      open_d = 1'b1;
    end

    if (bit_xfer) begin
      sh_d  = sh_q << 1;
      rem_d = rem_q - LEN_W'(1);
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (sym_xfer) begin
          if (ent_len != '0) begin
            sh_d    = ent_code << (LEN_W'(MAX_LEN) - ent_len);
            rem_d   = ent_len;
            last_d  = sym_last;
            state_d = ST_SHIFT;
          end else begin
            err_d   = 1'b1;
            state_d = sym_last ? ST_DONE : ST_IDLE;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_xfer && final_bit) begin
          if (sym_xfer) begin
            if (ent_len != '0) begin
              sh_d   = ent_code << (LEN_W'(MAX_LEN) - ent_len);
              rem_d  = ent_len;
              last_d = sym_last;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            state_d = last_q ? ST_DONE : ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        open_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    // Table writes are only legal while idle.
    if (tbl_we && ((state_q != ST_IDLE) || tbl_werr)) err_d = 1'b1;
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      open_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      open_q  <= open_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_huffman_code_serializer.sv
// Directed bench for huffman_code_serializer: default-geometry instance
// plus a MAX_LEN=7 instance for the over-length table write case.
module tb_huffman_code_serializer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [14:0] tbl_code;
  logic [3:0]  tbl_len;
  logic [3:0]  sym_in;
  logic        sym_valid, sym_last, sym_ready;
  logic        bit_out, bit_valid, bit_ready;
  logic        output_start, done, err;
  logic [15:0] bit_count;

  logic        tbl_we7;
  logic [3:0]  tbl_addr7;
  logic [6:0]  tbl_code7;
  logic [3:0]  tbl_len7;
  logic [3:0]  sym_in7;
  logic        sym_valid7, sym_last7, sym_ready7;
  logic        bit_out7, bit_valid7, bit_ready7;
  logic        output_start7, done7, err7;
  logic [15:0] bit_count7;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // results of the last run_block
  logic [31:0] r_bits;
  int          r_nbits, r_nstart, r_start_cyc, r_start_idx, r_done_cyc;
  int          r_hold_bad, r_sr_bad, r_sr_shift;
  logic        r_err_start, r_err_done, r_done;
  logic [15:0] r_cnt_done;

  always #5 CLK = ~CLK;

  huffman_code_serializer dut (
    .CLK(CLK), .nRST(nRST),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .output_start(output_start), .done(done), .bit_count(bit_count), .err(err)
  );

  huffman_code_serializer #(.MAX_LEN(7)) dut7 (
    .CLK(CLK), .nRST(nRST),
    .tbl_we(tbl_we7), .tbl_addr(tbl_addr7), .tbl_code(tbl_code7), .tbl_len(tbl_len7),
    .sym_in(sym_in7), .sym_valid(sym_valid7), .sym_last(sym_last7), .sym_ready(sym_ready7),
    .bit_out(bit_out7), .bit_valid(bit_valid7), .bit_ready(bit_ready7),
    .output_start(output_start7), .done(done7), .bit_count(bit_count7), .err(err7)
  );

  task automatic tbl_write(input logic [3:0] a, input logic [14:0] c, input logic [3:0] l);
    @(negedge CLK);
    tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
    @(negedge CLK);
    tbl_we = 1'b0;
  endtask

  // Drive one block of symbols, capture the bit stream and framing events.
  task automatic run_block(input int nsym, input logic [7:0][3:0] syms,
                           input bit toggle, input int we_cyc);
    int   si;
    bit   prev_stall;
    logic prev_bit;
    si = 0; prev_stall = 0; prev_bit = 1'b0;
    r_bits = '0; r_nbits = 0; r_nstart = 0; r_start_cyc = -1; r_start_idx = -1;
    r_done_cyc = -1; r_hold_bad = 0; r_sr_bad = 0; r_sr_shift = 0;
    r_err_start = 1'bx; r_err_done = 1'bx; r_done = 1'b0; r_cnt_done = 'x;
    for (int cyc = 0; cyc < 200 && !r_done; cyc++) begin
      @(negedge CLK);
      if (si < nsym) begin
        sym_valid = 1'b1; sym_in = syms[si]; sym_last = (si == nsym - 1);
      end else begin
        sym_valid = 1'b0; sym_last = 1'b0;
      end
      bit_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == we_cyc) begin
        tbl_we = 1'b1; tbl_addr = 4'd9; tbl_code = 15'h7; tbl_len = 4'd3;
      end else begin
        tbl_we = 1'b0;
      end
      #1;
      if (prev_stall && (bit_valid !== 1'b1 || bit_out !== prev_bit)) r_hold_bad++;
      if (output_start === 1'b1) begin
        r_nstart++; r_start_cyc = cyc; r_start_idx = r_nbits; r_err_start = err;
      end
      if (sym_ready && bit_valid) begin
        r_sr_shift++;
        if (!bit_ready) r_sr_bad++;
      end
      if (bit_valid && bit_ready) begin
        r_bits = {r_bits[30:0], bit_out}; r_nbits++;
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      if (sym_valid && sym_ready) si++;
      if (done === 1'b1) begin
        r_done = 1'b1; r_done_cyc = cyc; r_cnt_done = bit_count; r_err_done = err;
      end
    end
    sym_valid = 1'b0; sym_last = 1'b0; tbl_we = 1'b0; bit_ready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge CLK); #1;
    chk_cnt++; if (sym_ready !== 1'b1) $display("FAIL reset sym_ready: got %b want 1", sym_ready); else pass_cnt++;
    chk_cnt++; if (bit_valid !== 1'b0) $display("FAIL reset bit_valid: got %b want 0", bit_valid); else pass_cnt++;
    chk_cnt++; if (bit_out !== 1'b0) $display("FAIL reset bit_out: got %b want 0", bit_out); else pass_cnt++;
    chk_cnt++; if (output_start !== 1'b0) $display("FAIL reset output_start: got %b want 0", output_start); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (bit_count !== 16'd0) $display("FAIL reset bit_count: got %0d want 0", bit_count); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err); else pass_cnt++;
  endtask

  // 9 -> 00, 0 -> 10110; stream 0010110 back to back.
  task automatic test_basic_stream;
    logic [7:0][3:0] s;
    tbl_write(4'd9, 15'b00, 4'd2);
    tbl_write(4'd0, 15'b10110, 4'd5);
    s = '0; s[0] = 4'd9; s[1] = 4'd0;
    run_block(2, s, 1'b0, -1);
    chk_cnt++; if (r_done !== 1'b1) $display("FAIL basic done_seen: got %b want 1", r_done); else pass_cnt++;
    chk_cnt++; if (r_bits[6:0] !== 7'b0010110 || r_nbits != 7) $display("FAIL basic bits: got %b/%0d want 0010110/7", r_bits[6:0], r_nbits); else pass_cnt++;
    chk_cnt++; if (r_nstart != 1 || r_start_cyc != 1 || r_start_idx != 0) $display("FAIL basic output_start: got n=%0d cyc=%0d idx=%0d want 1/1/0", r_nstart, r_start_cyc, r_start_idx); else pass_cnt++;
    chk_cnt++; if (r_done_cyc != 8) $display("FAIL basic done_cycle: got %0d want 8", r_done_cyc); else pass_cnt++;
    chk_cnt++; if (r_cnt_done !== 16'd7) $display("FAIL basic bit_count: got %0d want 7", r_cnt_done); else pass_cnt++;
    chk_cnt++; if (r_sr_shift != 1) $display("FAIL basic sym_ready_in_shift: got %0d want 1", r_sr_shift); else pass_cnt++;
    chk_cnt++; if (r_err_done !== 1'b0) $display("FAIL basic err: got %b want 0", r_err_done); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [7:0][3:0] s;
    s = '0; s[0] = 4'd9; s[1] = 4'd0;
    run_block(2, s, 1'b1, -1);
    chk_cnt++; if (r_bits[6:0] !== 7'b0010110 || r_nbits != 7) $display("FAIL bp bits: got %b/%0d want 0010110/7", r_bits[6:0], r_nbits); else pass_cnt++;
    chk_cnt++; if (r_hold_bad != 0) $display("FAIL bp hold: got %0d unstable stalls want 0", r_hold_bad); else pass_cnt++;
    chk_cnt++; if (r_sr_bad != 0 || r_sr_shift != 1) $display("FAIL bp sym_ready: got bad=%0d shift=%0d want 0/1", r_sr_bad, r_sr_shift); else pass_cnt++;
    chk_cnt++; if (r_nstart != 1) $display("FAIL bp output_start_count: got %0d want 1", r_nstart); else pass_cnt++;
    chk_cnt++; if (r_done_cyc != 15 || r_cnt_done !== 16'd7) $display("FAIL bp done: got cyc=%0d cnt=%0d want 15/7", r_done_cyc, r_cnt_done); else pass_cnt++;
  endtask

  task automatic test_drop;
    logic [7:0][3:0] s;
    @(negedge CLK);
    sym_in = 4'd3; sym_valid = 1'b1; sym_last = 1'b0;
    @(negedge CLK);
    sym_valid = 1'b0; #1;
    chk_cnt++; if (err !== 1'b1) $display("FAIL drop err_set: got %b want 1", err); else pass_cnt++;
    chk_cnt++; if (bit_valid !== 1'b0 || sym_ready !== 1'b1) $display("FAIL drop idle: got bv=%b sr=%b want 0/1", bit_valid, sym_ready); else pass_cnt++;
    s = '0; s[0] = 4'd9;
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_bits[1:0] !== 2'b00 || r_nbits != 2) $display("FAIL drop bits: got %b/%0d want 00/2", r_bits[1:0], r_nbits); else pass_cnt++;
    chk_cnt++; if (r_err_start !== 1'b1 || r_err_done !== 1'b0) $display("FAIL drop err_clear: got start=%b done=%b want 1/0", r_err_start, r_err_done); else pass_cnt++;
    // block made only of a dropped symbol
    s[0] = 4'd3;
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_done !== 1'b1 || r_nstart != 0 || r_nbits != 0) $display("FAIL drop_all framing: got done=%b start=%0d bits=%0d want 1/0/0", r_done, r_nstart, r_nbits); else pass_cnt++;
    chk_cnt++; if (r_cnt_done !== 16'd2 || r_err_done !== 1'b1) $display("FAIL drop_all count_err: got %0d/%b want 2/1", r_cnt_done, r_err_done); else pass_cnt++;
  endtask

  task automatic test_tbl_we_busy;
    logic [7:0][3:0] s;
    s = '0; s[0] = 4'd9; s[1] = 4'd0;
    run_block(2, s, 1'b0, 2);
    chk_cnt++; if (r_bits[6:0] !== 7'b0010110) $display("FAIL busy_we bits: got %b want 0010110", r_bits[6:0]); else pass_cnt++;
    chk_cnt++; if (r_err_done !== 1'b1) $display("FAIL busy_we err: got %b want 1", r_err_done); else pass_cnt++;
    s = '0; s[0] = 4'd9;
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_bits[1:0] !== 2'b00 || r_nbits != 2) $display("FAIL busy_we entry: got %b/%0d want 00/2", r_bits[1:0], r_nbits); else pass_cnt++;
  endtask

  task automatic test_maxlen;
    logic [7:0][3:0] s;
    tbl_write(4'd5, 15'h7FFF, 4'd15);
    s = '0; s[0] = 4'd5;
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_bits[14:0] !== 15'h7FFF || r_nbits != 15) $display("FAIL maxlen ones: got %h/%0d want 7fff/15", r_bits[14:0], r_nbits); else pass_cnt++;
    chk_cnt++; if (r_cnt_done !== 16'd15) $display("FAIL maxlen bit_count: got %0d want 15", r_cnt_done); else pass_cnt++;
    tbl_write(4'd6, 15'h4001, 4'd15);
    s[0] = 4'd6;
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_bits[14:0] !== 15'h4001 || r_nbits != 15) $display("FAIL maxlen order: got %h/%0d want 4001/15", r_bits[14:0], r_nbits); else pass_cnt++;
  endtask

  task automatic test_overlen;
    logic [6:0] bits7;
    int         n7, si7;
    logic       e_start, seen_done;
    logic [1:0][3:0] s7;
    chk_cnt++; if (err7 !== 1'b0) $display("FAIL overlen err_init: got %b want 0", err7); else pass_cnt++;
    @(negedge CLK);
    tbl_we7 = 1'b1; tbl_addr7 = 4'd2; tbl_code7 = 7'h7F; tbl_len7 = 4'd9;
    @(negedge CLK);
    tbl_we7 = 1'b1; tbl_addr7 = 4'd1; tbl_code7 = 7'h55; tbl_len7 = 4'd7;
    #1;
    chk_cnt++; if (err7 !== 1'b1) $display("FAIL overlen err_set: got %b want 1", err7); else pass_cnt++;
    @(negedge CLK);
    tbl_we7 = 1'b0;
    s7[0] = 4'd2; s7[1] = 4'd1;
    bits7 = '0; n7 = 0; si7 = 0; e_start = 1'bx; seen_done = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      @(negedge CLK);
      if (si7 < 2) begin
        sym_valid7 = 1'b1; sym_in7 = s7[si7]; sym_last7 = (si7 == 1);
      end else begin
        sym_valid7 = 1'b0; sym_last7 = 1'b0;
      end
      #1;
      if (output_start7 === 1'b1) e_start = err7;
      if (bit_valid7 && bit_ready7) begin bits7 = {bits7[5:0], bit_out7}; n7++; end
      if (sym_valid7 && sym_ready7) si7++;
      if (done7 === 1'b1) begin
        seen_done = 1'b1;
        chk_cnt++; if (bit_count7 !== 16'd7 || err7 !== 1'b0) $display("FAIL overlen done_state: got cnt=%0d err=%b want 7/0", bit_count7, err7); else pass_cnt++;
      end
    end
    sym_valid7 = 1'b0; sym_last7 = 1'b0;
    chk_cnt++; if (seen_done !== 1'b1) $display("FAIL overlen done_seen: got %b want 1", seen_done); else pass_cnt++;
    chk_cnt++; if (bits7 !== 7'b1010101 || n7 != 7) $display("FAIL overlen bits: got %b/%0d want 1010101/7", bits7, n7); else pass_cnt++;
    chk_cnt++; if (e_start !== 1'b1) $display("FAIL overlen err_at_start: got %b want 1", e_start); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [7:0][3:0] s;
    @(negedge CLK);
    sym_in = 4'd0; sym_valid = 1'b1; sym_last = 1'b1; bit_ready = 1'b1;
    @(negedge CLK);
    sym_valid = 1'b0; sym_last = 1'b0;
    @(negedge CLK);
    @(negedge CLK); #1;
    chk_cnt++; if (bit_valid !== 1'b1 || bit_out !== 1'b1) $display("FAIL rstmid bit3: got bv=%b bo=%b want 1/1", bit_valid, bit_out); else pass_cnt++;
    nRST = 1'b0; #1;
    chk_cnt++; if (bit_valid !== 1'b0 || sym_ready !== 1'b1) $display("FAIL rstmid abort: got bv=%b sr=%b want 0/1", bit_valid, sym_ready); else pass_cnt++;
    chk_cnt++; if (bit_count !== 16'd0 || done !== 1'b0) $display("FAIL rstmid regs: got cnt=%0d done=%b want 0/0", bit_count, done); else pass_cnt++;
    @(negedge CLK);
    nRST = 1'b1;
    s = '0; s[0] = 4'd9;
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_done !== 1'b1 || r_nbits != 0 || r_err_done !== 1'b1) $display("FAIL rstmid table_cleared: got done=%b bits=%0d err=%b want 1/0/1", r_done, r_nbits, r_err_done); else pass_cnt++;
    tbl_write(4'd9, 15'b00, 4'd2);
    run_block(1, s, 1'b0, -1);
    chk_cnt++; if (r_nstart != 1 || r_start_idx != 0) $display("FAIL rstmid fresh_start: got n=%0d idx=%0d want 1/0", r_nstart, r_start_idx); else pass_cnt++;
    chk_cnt++; if (r_bits[1:0] !== 2'b00 || r_nbits != 2) $display("FAIL rstmid bits: got %b/%0d want 00/2", r_bits[1:0], r_nbits); else pass_cnt++;
  endtask

  initial begin
    nRST = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
    sym_in = '0; sym_valid = 1'b0; sym_last = 1'b0; bit_ready = 1'b1;
    tbl_we7 = 1'b0; tbl_addr7 = '0; tbl_code7 = '0; tbl_len7 = '0;
    sym_in7 = '0; sym_valid7 = 1'b0; sym_last7 = 1'b0; bit_ready7 = 1'b1;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    test_reset;
    test_basic_stream;
    test_backpressure;
    test_drop;
    test_tbl_we_busy;
    test_maxlen;
    test_overlen;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
